// File: rtl/tri_mode_ethernet_mac_tx.sv
// Tri-speed Ethernet MAC transmitter: frames AXI-Stream bytes into preamble/SFD/data/pad/FCS
// wire bytes for the RGMII layer and enforces the inter-frame gap.
module tri_mode_ethernet_mac_tx #(
   parameter int unsigned C_MIN_FRAME    = 60,
   parameter int unsigned C_IFG          = 12,
   parameter int unsigned C_PREAMBLE_LEN = 7
) (
   input  logic       tx_mac_aclk,
   input  logic       tx_mac_resetn,
   input  logic [1:0] inband_clock_speed,
   input  logic [7:0] tx_axis_mac_tdata,
   input  logic       tx_axis_mac_tvalid,
   input  logic       tx_axis_mac_tlast,
   input  logic       tx_axis_mac_tuser,
   output logic       tx_axis_mac_tready,
   output logic [7:0] tx_axis_rgmii_tdata,
   output logic       tx_axis_rgmii_tvalid,
   output logic       tx_underrun,
   output logic       tx_frame_done
);

   typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_IFG} state_t;

   state_t      state;
   logic        speed_fast;
   logic        phase;
   logic        strobe;
   logic        bad_frame;
   logic        drain;
   logic [3:0]  pre_cnt;
   logic [10:0] byte_cnt;
   logic [10:0] byte_cnt_inc;
   logic [2:0]  fcs_idx;
   logic [15:0] ifg_cnt;
   logic [31:0] ifg_cycles;
   logic [31:0] crc;
   logic [31:0] crc_data;
   logic [31:0] crc_pad;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;
   logic        reached_min;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'h000000, d};
      for (int unsigned i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   always_comb begin
      strobe             = speed_fast | phase;
      tx_axis_mac_tready = ((state == S_DATA) && strobe) || ((state == S_IDLE) && drain);
      byte_cnt_inc       = (byte_cnt == '1) ? byte_cnt : byte_cnt + 11'd1;
      reached_min        = (32'(byte_cnt) + 32'd1) >= C_MIN_FRAME;
      crc_data           = crc_byte(crc, tx_axis_mac_tdata);
      crc_pad            = crc_byte(crc, 8'h00);
      fcs_word           = bad_frame ? crc : ~crc;
      fcs_byte           = fcs_word[{fcs_idx[1:0], 3'b000} +: 8];
      // The gap spans C_IFG byte times; the IDLE cycle that launches the next
      // preamble is its last cycle, so S_IFG itself lasts one cycle less.
      ifg_cycles         = speed_fast ? C_IFG : 2 * C_IFG;
   end

   always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
      if (!tx_mac_resetn) begin
         state                <= S_IDLE;
         speed_fast           <= 1'b0;
         phase                <= 1'b0;
         bad_frame            <= 1'b0;
         drain                <= 1'b0;
         pre_cnt              <= '0;
         byte_cnt             <= '0;
         fcs_idx              <= '0;
         ifg_cnt              <= '0;
         crc                  <= '1;
         tx_axis_rgmii_tdata  <= '0;
         tx_axis_rgmii_tvalid <= 1'b0;
         tx_underrun          <= 1'b0;
         tx_frame_done        <= 1'b0;
      end else begin
         tx_underrun   <= 1'b0;
         tx_frame_done <= 1'b0;
         phase         <= ~phase;
         case (state)
            S_IDLE: begin
               if (drain) begin
                  if (tx_axis_mac_tvalid && tx_axis_mac_tlast)
                     drain <= 1'b0;
               end else if (tx_axis_mac_tvalid) begin
                  state                <= S_PREAMBLE;
                  speed_fast           <= (inband_clock_speed == 2'b10) || (inband_clock_speed == 2'b11);
                  phase                <= 1'b0;
                  crc                  <= '1;
                  byte_cnt             <= '0;
                  pre_cnt              <= 4'd1;
                  bad_frame            <= 1'b0;
                  fcs_idx              <= '0;
                  tx_axis_rgmii_tdata  <= 8'h55;
                  tx_axis_rgmii_tvalid <= 1'b1;
               end
            end
            S_PREAMBLE: begin
               if (strobe) begin
                  if (32'(pre_cnt) < C_PREAMBLE_LEN) begin
                     tx_axis_rgmii_tdata <= 8'h55;
                     pre_cnt             <= pre_cnt + 4'd1;
                  end else begin
                     tx_axis_rgmii_tdata <= 8'hD5;
                     state               <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (strobe) begin
                  if (tx_axis_mac_tvalid) begin
                     tx_axis_rgmii_tdata <= tx_axis_mac_tdata;
                     crc                 <= crc_data;
                     byte_cnt            <= byte_cnt_inc;
                     if (tx_axis_mac_tlast) begin
                        bad_frame <= tx_axis_mac_tuser;
                        state     <= reached_min ? S_FCS : S_PAD;
                     end
                  end else begin
                     // Underrun: this strobe already carries the first pad or FCS
                     // byte so the envelope stays gap-free.
                     tx_underrun <= 1'b1;
                     bad_frame   <= 1'b1;
                     drain       <= 1'b1;
                     if (32'(byte_cnt) < C_MIN_FRAME) begin
                        tx_axis_rgmii_tdata <= 8'h00;
                        crc                 <= crc_pad;
                        byte_cnt            <= byte_cnt_inc;
                        state               <= reached_min ? S_FCS : S_PAD;
                     end else begin
                        tx_axis_rgmii_tdata <= crc[7:0];
                        fcs_idx             <= 3'd1;
                        state               <= S_FCS;
                     end
                  end
               end
            end
            S_PAD: begin
               if (strobe) begin
                  tx_axis_rgmii_tdata <= 8'h00;
                  crc                 <= crc_pad;
                  byte_cnt            <= byte_cnt_inc;
                  if (reached_min)
                     state <= S_FCS;
               end
            end
            S_FCS: begin
               if (strobe) begin
                  if (fcs_idx == 3'd4) begin
                     tx_axis_rgmii_tdata  <= 8'h00;
                     tx_axis_rgmii_tvalid <= 1'b0;
                     tx_frame_done        <= 1'b1;
                     fcs_idx              <= '0;
                     ifg_cnt              <= '0;
                     state                <= S_IFG;
                  end else begin
                     tx_axis_rgmii_tdata <= fcs_byte;
                     fcs_idx             <= fcs_idx + 3'd1;
                  end
               end
            end
            S_IFG: begin
               if ((32'(ifg_cnt) + 32'd2) >= ifg_cycles) begin
                  ifg_cnt <= '0;
                  state   <= S_IDLE;
               end else begin
                  ifg_cnt <= ifg_cnt + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tri_mode_ethernet_mac_tx.sv
// Randomized bench for tri_mode_ethernet_mac_tx; expected wire frames come from an MSB-first
// CRC model over the padded payload, compared cycle by cycle against captured output.
module tb_tri_mode_ethernet_mac_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] speed = 2'b10;
   logic [7:0] tdata = '0;
   logic       tvalid = 1'b0;
   logic       tlast = 1'b0;
   logic       tuser = 1'b0;
   logic       tready;
   logic [7:0] rg_tdata;
   logic       rg_tvalid;
   logic       underrun;
   logic       frame_done;

   tri_mode_ethernet_mac_tx #(.C_MIN_FRAME(60), .C_IFG(12), .C_PREAMBLE_LEN(7)) dut (
      .tx_mac_aclk          (clk),
      .tx_mac_resetn        (rst_n),
      .inband_clock_speed   (speed),
      .tx_axis_mac_tdata    (tdata),
      .tx_axis_mac_tvalid   (tvalid),
      .tx_axis_mac_tlast    (tlast),
      .tx_axis_mac_tuser    (tuser),
      .tx_axis_mac_tready   (tready),
      .tx_axis_rgmii_tdata  (rg_tdata),
      .tx_axis_rgmii_tvalid (rg_tvalid),
      .tx_underrun          (underrun),
      .tx_frame_done        (frame_done)
   );

   initial forever #4 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // capture of the wire side, one sample per clock
   int         cyc = 0;
   bit         in_frame = 1'b0;
   logic [7:0] cap_q[$];
   int         fstart[$];
   int         flen[$];
   int         fsc[$];
   int         fec[$];
   int         done_cyc[$];
   int         under_cnt = 0;
   int         done_cnt = 0;
   int         ready_cnt = 0;
   bit         ready_prev = 1'b0;
   bit         ready_b2b = 1'b0;

   logic [7:0] pay_q[$];
   logic [7:0] exp_q[$];
   bit         drive_timeout;
   bit         wait_timeout;

   initial forever begin
      @(negedge clk);
      cyc++;
      if (rg_tvalid) begin
         if (!in_frame) begin
            in_frame = 1'b1;
            fstart.push_back(cap_q.size());
            fsc.push_back(cyc);
         end
         cap_q.push_back(rg_tdata);
      end else if (in_frame) begin
         in_frame = 1'b0;
         flen.push_back(cap_q.size() - fstart[fstart.size() - 1]);
         fec.push_back(cyc - 1);
      end
      if (underrun) under_cnt++;
      if (frame_done) begin
         done_cnt++;
         done_cyc.push_back(cyc);
      end
      if (tready) ready_cnt++;
      if (tready && ready_prev) ready_b2b = 1'b1;
      ready_prev = tready;
   end

   task automatic clear_capture();
      cap_q.delete(); fstart.delete(); flen.delete(); fsc.delete(); fec.delete();
      done_cyc.delete();
      under_cnt = 0; done_cnt = 0; ready_cnt = 0; ready_b2b = 1'b0;
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7 - i];
      return r;
   endfunction

   function automatic logic [31:0] rev32(input logic [31:0] b);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = b[31 - i];
      return r;
   endfunction

   // Non-reflected CRC-32 (0x04C11DB7, MSB first) on bit-reversed bytes.
   function automatic logic [31:0] crc_msb_step(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {rev8(b), 24'h000000};
      for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
      return r;
   endfunction

   task automatic fill_payload(input int n);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // Wire image: preamble, SFD, first `sent` payload bytes, zero pad to 60, FCS LSB first.
   task automatic build_expected(input int sent, input bit bad);
      logic [31:0] c;
      logic [31:0] fcs;
      int          body;
      exp_q.delete();
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      c = 32'hFFFFFFFF;
      body = 0;
      for (int i = 0; i < sent; i++) begin
         exp_q.push_back(pay_q[i]);
         c = crc_msb_step(c, pay_q[i]);
         body++;
      end
      while (body < 60) begin
         exp_q.push_back(8'h00);
         c = crc_msb_step(c, 8'h00);
         body++;
      end
      fcs = bad ? rev32(c) : ~rev32(c);
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(fcs >> (8 * i)));
   endtask

   function automatic int frame_length(input int f);
      if (f >= flen.size()) return -1;
      return flen[f];
   endfunction

   function automatic int frame_mismatch(input int f, input int period);
      int n;
      if (f >= flen.size()) return -1;
      if (flen[f] != exp_q.size() * period) return -2;
      n = 0;
      for (int i = 0; i < flen[f]; i++)
         if (cap_q[fstart[f] + i] !== exp_q[i / period]) n++;
      return n;
   endfunction

   function automatic logic [31:0] frame_residue(input int f, input int period);
      logic [31:0] c;
      if (f >= flen.size()) return 32'h0;
      c = 32'hFFFFFFFF;
      for (int k = 8; k < flen[f] / period; k++) c = crc_msb_step(c, cap_q[fstart[f] + k * period]);
      return rev32(c);
   endfunction

   function automatic int frame_gap(input int f);
      if (f + 1 >= fsc.size() || f >= fec.size()) return -1;
      return fsc[f + 1] - fec[f] - 1;
   endfunction

   task automatic drive_frame(input int n, input bit user, input int drop_after, input int stop_after);
      bit accepted;
      int budget;
      drive_timeout = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (stop_after >= 0 && i == stop_after) return;
         if (drop_after >= 0 && i == drop_after) begin
            tvalid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
         end
         tdata = pay_q[i]; tvalid = 1'b1; tlast = (i == n - 1); tuser = user && (i == n - 1);
         accepted = 1'b0;
         budget = 0;
         while (!accepted && budget < 3000) begin
            @(negedge clk);
            if (tready) accepted = 1'b1;
            @(posedge clk);
            #1;
            budget++;
         end
         if (!accepted) begin
            drive_timeout = 1'b1;
            tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
            return;
         end
      end
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
   endtask

   task automatic wait_frames(input int n);
      int b = 0;
      while (flen.size() < n && b < 5000) begin
         @(posedge clk);
         b++;
      end
      wait_timeout = (flen.size() < n);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rg_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", rg_tvalid); end
      checks++; if (rg_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h want 00", rg_tdata); end
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", tready); end
      checks++; if ({underrun, frame_done} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {underrun, frame_done}); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL idle_tready got %b want 0", tready); end
   endtask

   task automatic test_full_speed();
      clear_capture();
      speed = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      fill_payload(64);
      build_expected(64, 1'b0);
      drive_frame(64, 1'b0, -1, -1);
      wait_frames(1);
      repeat (16) @(posedge clk);
      checks++; if (drive_timeout || wait_timeout) begin errors++; $display("FAIL full_timeout got %b%b want 00", drive_timeout, wait_timeout); end
      checks++; if (frame_length(0) !== 76) begin errors++; $display("FAIL full_envelope got %0d want 76", frame_length(0)); end
      checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL full_wire got %0d bad cycles want 0", frame_mismatch(0, 1)); end
      checks++; if (frame_residue(0, 1) !== 32'hDEBB20E3) begin errors++; $display("FAIL full_residue got %h want debb20e3", frame_residue(0, 1)); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
      checks++;
      if (done_cyc.size() < 1 || fec.size() < 1 || done_cyc[0] != fec[0] + 1) begin
         errors++; $display("FAIL full_done_timing got %0d want %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, (fec.size() > 0) ? fec[0] + 1 : -1);
      end
      checks++; if (flen.size() !== 1 || rg_tvalid !== 1'b0) begin errors++; $display("FAIL full_quiet got %0d frames want 1", flen.size()); end
   endtask

   task automatic test_short_pad();
      clear_capture();
      speed = 2'b10;
      fill_payload(14);
      build_expected(14, 1'b0);
      drive_frame(14, 1'b0, -1, -1);
      wait_frames(1);
      repeat (4) @(posedge clk);
      checks++; if (frame_length(0) - 8 !== 64) begin errors++; $display("FAIL pad14_post_sfd got %0d want 64", frame_length(0) - 8); end
      checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL pad14_wire got %0d bad cycles want 0", frame_mismatch(0, 1)); end
      checks++; if (frame_residue(0, 1) !== 32'hDEBB20E3) begin errors++; $display("FAIL pad14_residue got %h want debb20e3", frame_residue(0, 1)); end
   endtask

   task automatic test_boundaries();
      int lens[2] = '{1, 60};
      for (int k = 0; k < 2; k++) begin
         clear_capture();
         speed = 2'b10;
         fill_payload(lens[k]);
         build_expected(lens[k], 1'b0);
         drive_frame(lens[k], 1'b0, -1, -1);
         wait_frames(1);
         repeat (14) @(posedge clk);
         checks++; if (frame_length(0) !== 72) begin errors++; $display("FAIL bound%0d_envelope got %0d want 72", lens[k], frame_length(0)); end
         checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL bound%0d_wire got %0d bad cycles want 0", lens[k], frame_mismatch(0, 1)); end
      end
   endtask

   task automatic test_half_speed();
      clear_capture();
      speed = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b00;
      fill_payload(60);
      build_expected(60, 1'b0);
      drive_frame(60, 1'b0, -1, -1);
      fill_payload(60);
      drive_frame(60, 1'b0, -1, -1);
      wait_frames(2);
      repeat (4) @(posedge clk);
      checks++; if (wait_timeout || drive_timeout) begin errors++; $display("FAIL half_timeout got %b%b want 00", wait_timeout, drive_timeout); end
      checks++; if (frame_length(0) !== 144) begin errors++; $display("FAIL half_envelope got %0d want 144", frame_length(0)); end
      checks++; if (frame_mismatch(0, 2) !== 0) begin errors++; $display("FAIL half_wire0 got %0d bad cycles want 0", frame_mismatch(0, 2)); end
      checks++; if (frame_gap(0) !== 24) begin errors++; $display("FAIL half_ifg got %0d want 24", frame_gap(0)); end
      checks++; if (ready_b2b !== 1'b0) begin errors++; $display("FAIL half_ready_alternate got %b want 0", ready_b2b); end
      checks++; if (ready_cnt !== 120) begin errors++; $display("FAIL half_ready_count got %0d want 120", ready_cnt); end
      build_expected(60, 1'b0);
      checks++; if (frame_mismatch(1, 2) !== 0) begin errors++; $display("FAIL half_wire1 got %0d bad cycles want 0", frame_mismatch(1, 2)); end
   endtask

   task automatic test_underrun();
      clear_capture();
      speed = 2'b10;
      fill_payload(100);
      build_expected(30, 1'b1);
      drive_frame(100, 1'b0, 30, -1);
      wait_frames(1);
      repeat (20) @(posedge clk);
      #1;
      checks++; if (drive_timeout !== 1'b0) begin errors++; $display("FAIL underrun_drain got timeout %b want 0", drive_timeout); end
      checks++; if (under_cnt !== 1) begin errors++; $display("FAIL underrun_pulses got %0d want 1", under_cnt); end
      checks++; if (frame_length(0) !== 72) begin errors++; $display("FAIL underrun_envelope got %0d want 72", frame_length(0)); end
      checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL underrun_wire got %0d bad cycles want 0", frame_mismatch(0, 1)); end
      checks++; if (frame_residue(0, 1) === 32'hDEBB20E3) begin errors++; $display("FAIL underrun_residue got %h want not debb20e3", frame_residue(0, 1)); end
      checks++; if (flen.size() !== 1 || done_cnt !== 1) begin errors++; $display("FAIL underrun_frames got %0d/%0d want 1/1", flen.size(), done_cnt); end
      checks++; if (tready !== 1'b0) begin errors++; $display("FAIL underrun_tready_after got %b want 0", tready); end
   endtask

   task automatic test_back_to_back();
      int n2;
      clear_capture();
      speed = 2'b10;
      fill_payload(64);
      build_expected(64, 1'b1);
      drive_frame(64, 1'b1, -1, -1);
      n2 = $urandom_range(20, 80);
      fill_payload(n2);
      drive_frame(n2, 1'b0, -1, -1);
      wait_frames(2);
      repeat (4) @(posedge clk);
      checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL b2b_bad_wire got %0d bad cycles want 0", frame_mismatch(0, 1)); end
      checks++; if (frame_residue(0, 1) === 32'hDEBB20E3) begin errors++; $display("FAIL b2b_bad_residue got %h want not debb20e3", frame_residue(0, 1)); end
      checks++; if (frame_gap(0) !== 12) begin errors++; $display("FAIL b2b_ifg got %0d want 12", frame_gap(0)); end
      build_expected(n2, 1'b0);
      checks++; if (frame_mismatch(1, 1) !== 0) begin errors++; $display("FAIL b2b_second_wire got %0d bad cycles want 0", frame_mismatch(1, 1)); end
      checks++; if (frame_residue(1, 1) !== 32'hDEBB20E3) begin errors++; $display("FAIL b2b_second_residue got %h want debb20e3", frame_residue(1, 1)); end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
   endtask

   task automatic test_reset_mid_frame();
      int n;
      clear_capture();
      speed = 2'b10;
      fill_payload(50);
      drive_frame(50, 1'b0, -1, 20);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({rg_tvalid, tready, underrun, frame_done} !== 4'b0000) begin errors++; $display("FAIL midrst_flags got %b want 0000", {rg_tvalid, tready, underrun, frame_done}); end
      checks++; if (rg_tdata !== 8'h00) begin errors++; $display("FAIL midrst_tdata got %h want 00", rg_tdata); end
      tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", done_cnt); end
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clear_capture();
      n = $urandom_range(30, 70);
      fill_payload(n);
      build_expected(n, 1'b0);
      drive_frame(n, 1'b0, -1, -1);
      wait_frames(1);
      repeat (4) @(posedge clk);
      checks++; if (frame_mismatch(0, 1) !== 0) begin errors++; $display("FAIL midrst_after_wire got %0d bad cycles want 0", frame_mismatch(0, 1)); end
      checks++; if (frame_residue(0, 1) !== 32'hDEBB20E3) begin errors++; $display("FAIL midrst_after_residue got %h want debb20e3", frame_residue(0, 1)); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midrst_after_done got %0d want 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_speed();
      test_short_pad();
      test_boundaries();
      test_half_speed();
      test_underrun();
      test_back_to_back();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
